// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: request FSM states, F/D payload and reset/bubble defaults.
// Pure declarations; no latency or backpressure of its own.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] inc_pc;
    } fd_t;

    function automatic fd_t fd_bubble(input logic [31:0] nop);
        fd_t b;
        b.instr  = nop;
        b.pc     = 32'd0;
        b.inc_pc = 32'd0;
        return b;
    endfunction

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fd_reg.sv
// F/D pipeline register: one-cycle latency, Flush loads a bubble, Stall holds the current entry.
module fd_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic flush_i,
    input  fd_t  fd_d_i,
    output fd_t  fd_q_o
);

    fd_t fd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_q <= fd_bubble(NOP_INSTR);
        end else if (flush_i) begin
            fd_q <= fd_bubble(NOP_INSTR);
        end else if (!stall_i) begin
            fd_q <= fd_d_i;
        end
    end

    assign fd_q_o = fd_q;

endmodule

// File: rtl/fetch.sv
// Fetch stage: one outstanding imem request, one-word hold buffer for stalls, and a drop state
// that swallows the response of a request overtaken by a redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] inc_PCD
);

    fetch_state_e state_q;
    logic [31:0]  pcf_q;
    logic [31:0]  ibuf_q;
    logic [31:0]  redir_q;
    fd_t          fd_d;
    fd_t          fd_q;

    // Decode gets a real word only when one is delivered and not overridden by a redirect.
    always_comb begin
        fd_d = fd_bubble(NOP_INSTR);
        if (!PCSrcE) begin
            if (state_q == ST_FETCH && imem_valid) begin
                fd_d.instr  = imem_rdata;
                fd_d.pc     = pcf_q;
                fd_d.inc_pc = pc_next(pcf_q);
            end else if (state_q == ST_HOLD) begin
                fd_d.instr  = ibuf_q;
                fd_d.pc     = pcf_q;
                fd_d.inc_pc = pc_next(pcf_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pcf_q   <= RESET_PC;
            ibuf_q  <= 32'd0;
            redir_q <= 32'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (PCSrcE) begin
                        if (imem_valid) begin
                            pcf_q <= PCTargetE;
                        end else begin
                            redir_q <= PCTargetE;
                            state_q <= ST_DROP;
                        end
                    end else if (imem_valid) begin
                        if (!Stall) begin
                            pcf_q <= pc_next(pcf_q);
                        end else begin
                            ibuf_q  <= imem_rdata;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (PCSrcE) begin
                        pcf_q   <= PCTargetE;
                        state_q <= ST_FETCH;
                    end else if (!Stall) begin
                        pcf_q   <= pc_next(pcf_q);
                        state_q <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (PCSrcE) begin
                        redir_q <= PCTargetE;
                    end
                    if (imem_valid) begin
                        pcf_q   <= PCSrcE ? PCTargetE : redir_q;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    fd_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk     (clk),
        .rst     (rst),
        .stall_i (Stall),
        .flush_i (Flush),
        .fd_d_i  (fd_d),
        .fd_q_o  (fd_q)
    );

    assign imem_req  = (state_q != ST_HOLD);
    assign imem_addr = pcf_q;
    assign InstrD    = fd_q.instr;
    assign PCD       = fd_q.pc;
    assign inc_PCD   = fd_q.inc_pc;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios with literal expectations, then randomized traffic
// against a transaction-level model of the fetch stage.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall, Flush, PCSrcE, imem_valid;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, InstrD, PCD, inc_PCD;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .Flush      (Flush),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .inc_PCD    (inc_PCD)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the stage is either awaiting a response (0), holding a delivered word (1),
    // or awaiting a response that must be thrown away (2).
    int          m_mode;
    logic [31:0] m_pc, m_buf, m_redir, m_instr, m_pcd, m_inc, m_word;
    logic        m_have;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  = 0;
            m_pc    = 32'h0;
            m_buf   = 32'h0;
            m_redir = 32'h0;
            m_instr = NOP;
            m_pcd   = 32'h0;
            m_inc   = 32'h0;
        end else begin
            m_have = 1'b0;
            m_word = 32'h0;
            if (!PCSrcE && m_mode == 0 && imem_valid) begin
                m_have = 1'b1;
                m_word = imem_rdata;
            end
            if (!PCSrcE && !Stall && m_mode == 1) begin
                m_have = 1'b1;
                m_word = m_buf;
            end
            if (Flush || (!Stall && !m_have)) begin
                m_instr = NOP; m_pcd = 32'h0; m_inc = 32'h0;
            end else if (!Stall) begin
                m_instr = m_word; m_pcd = m_pc; m_inc = m_pc + 32'd4;
            end
            if (PCSrcE) begin
                if (m_mode != 1 && !imem_valid) begin
                    m_redir = PCTargetE;
                    m_mode  = 2;
                end else begin
                    m_pc   = PCTargetE;
                    m_mode = 0;
                end
            end else if (m_mode == 2) begin
                if (imem_valid) begin
                    m_pc   = m_redir;
                    m_mode = 0;
                end
            end else if (m_have && !Stall) begin
                m_pc   = m_pc + 32'd4;
                m_mode = 0;
            end else if (m_mode == 0 && imem_valid && Stall) begin
                m_buf  = imem_rdata;
                m_mode = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model imem_req", {31'h0, imem_req}, {31'h0, (m_mode != 1)});
            if (m_mode != 1) chk("model imem_addr", imem_addr, m_pc);
            chk("model InstrD", InstrD, m_instr);
            chk("model PCD", PCD, m_pcd);
            chk("model inc_PCD", inc_PCD, m_inc);
        end
    end

    // Drive one cycle of inputs at the current negedge, then advance to the next negedge.
    task automatic step(input logic st, input logic fl, input logic br,
                        input logic [31:0] tg, input logic vld);
        Stall      = st;
        Flush      = fl;
        PCSrcE     = br;
        PCTargetE  = tg;
        imem_valid = vld;
        imem_rdata = memf(imem_addr);
        @(negedge clk);
    endtask

    task automatic fd_is(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] inc);
        chk({nm, " InstrD"}, InstrD, ins);
        chk({nm, " PCD"}, PCD, pc);
        chk({nm, " inc_PCD"}, inc_PCD, inc);
    endtask

    bit pend;
    int wcnt;

    initial begin
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        fd_is("reset", NOP, 32'h0, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset imem_req", {31'h0, imem_req}, 32'h1);
        chk("model reset pc", m_pc, 32'h0);

        // zero-wait stream
        step(0, 0, 0, 0, 1); fd_is("zw0", memf(32'h0), 32'h0, 32'h4);
        step(0, 0, 0, 0, 1); fd_is("zw1", memf(32'h4), 32'h4, 32'h8);
        step(0, 0, 0, 0, 1); fd_is("zw2", memf(32'h8), 32'h8, 32'hC);
        chk("zw addr", imem_addr, 32'hC);

        // three-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            fd_is("wait bubble", NOP, 32'h0, 32'h0);
            chk("wait addr", imem_addr, 32'hC);
        end
        step(0, 0, 0, 0, 1); fd_is("wait done", memf(32'hC), 32'hC, 32'h10);

        // stall while the response arrives
        step(1, 0, 0, 0, 1);
        chk("hold req", {31'h0, imem_req}, 32'h0);
        fd_is("hold1", memf(32'hC), 32'hC, 32'h10);
        step(1, 0, 0, 0, 0);
        chk("hold req2", {31'h0, imem_req}, 32'h0);
        fd_is("hold2", memf(32'hC), 32'hC, 32'h10);
        step(0, 0, 0, 0, 0);
        fd_is("hold release", memf(32'h10), 32'h10, 32'h14);
        chk("hold release addr", imem_addr, 32'h14);

        // redirect while a request is outstanding
        step(0, 0, 1, 32'h100, 0);
        chk("drop req", {31'h0, imem_req}, 32'h1);
        chk("drop addr stable", imem_addr, 32'h14);
        step(0, 0, 0, 0, 1);
        chk("drop stale gone", InstrD, NOP);
        chk("drop new addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1); fd_is("drop target", memf(32'h100), 32'h100, 32'h104);

        // PC wrap-around
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1); fd_is("wrap", memf(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        chk("wrap next addr", imem_addr, 32'h0);

        // flush beats stall
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1); fd_is("flush+stall", NOP, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0); fd_is("after flush", memf(32'h4), 32'h4, 32'h8);

        // reset in the middle of an outstanding request
        step(0, 0, 0, 0, 0);
        chk("pre-reset addr", imem_addr, 32'h8);
        #2 rst = 1'b1;
        #1;
        fd_is("async reset", NOP, 32'h0, 32'h0);
        chk("async reset addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("post-reset addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 1); fd_is("post-reset fetch", memf(32'h0), 32'h0, 32'h4);

        // randomized traffic with a variable-latency memory
        pend = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; imem_valid = 1'b0; pend = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                continue;
            end
            Stall     = ($urandom_range(0, 3) == 0);
            Flush     = ($urandom_range(0, 9) == 0);
            PCSrcE    = ($urandom_range(0, 9) == 0);
            PCTargetE = $urandom & 32'hFFFF_FFFC;
            if (imem_req) begin
                if (!pend) begin
                    pend = 1'b1;
                    wcnt = $urandom_range(0, 3);
                end
                if (wcnt == 0) begin
                    imem_valid = 1'b1;
                    pend = 1'b0;
                end else begin
                    imem_valid = 1'b0;
                    wcnt--;
                end
            end else begin
                imem_valid = 1'b0;
                pend = 1'b0;
            end
            imem_rdata = imem_valid ? memf(imem_addr) : $urandom;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-004 Stall  in  1  hazard-unit stall of PC and F/D register.
REQ-005 Flush  in  1  hazard-unit flush of F/D register.
REQ-006 PCSrcE  in  1  taken branch/jump redirect from execute.
REQ-007 PCTargetE  in  32  redirect target.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  request address, byte address.
REQ-010 imem_rdata  in  32  returned instruction.
REQ-011 imem_valid  in  1  one-cycle strobe, imem_rdata valid for the outstanding request.
REQ-012 InstrD / PCD / inc_PCD  out  32 each  F/D register outputs to decode.

Function
REQ-013 Memory protocol SHALL be: at most one outstanding request; imem_addr stable while imem_req=1 until imem_valid; imem_valid may be asserted in the same cycle as imem_req (zero-wait ROM).
REQ-014 States SHALL be FETCH (req=1, addr=PCF), HOLD (req=0, instruction in ibuf), DROP (req=1, addr=PCF, response to be discarded).
REQ-015 FETCH, PCSrcE=1: if imem_valid, discard data, PCF<=PCTargetE, stay FETCH; else redir_pc<=PCTargetE, go DROP.
REQ-016 FETCH, PCSrcE=0, imem_valid=1, Stall=0: F/D loads {imem_rdata, PCF, PCF+4}; PCF<=PCF+4; stay FETCH.
REQ-017 FETCH, PCSrcE=0, imem_valid=1, Stall=1: ibuf<=imem_rdata; PCF held; go HOLD.
REQ-018 FETCH, PCSrcE=0, imem_valid=0, Stall=0: F/D loads bubble {NOP_INSTR, 0, 0}; PCF held.
REQ-019 HOLD: PCSrcE=1 -> PCF<=PCTargetE, ibuf discarded, go FETCH; else Stall=0 -> F/D loads {ibuf, PCF, PCF+4}, PCF<=PCF+4, go FETCH; else remain.
REQ-020 DROP: PCSrcE=1 overwrites redir_pc; imem_valid=1 -> data discarded, PCF<=latest redirect (PCTargetE if PCSrcE=1 that cycle, else redir_pc), go FETCH; F/D receives bubble while Stall=0.
REQ-021 PCSrcE SHALL override Stall for PC update in every state.
REQ-022 F/D register priority SHALL be Flush (loads bubble) > Stall (holds) > load per REQ-016..020.
REQ-023 PC arithmetic SHALL be 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-024 Latency: with zero-wait memory and no stall, instruction at PCF SHALL appear on InstrD one cycle after request.

Reset
REQ-025 On rst: PCF=RESET_PC, state=FETCH, InstrD=NOP_INSTR, PCD=0, inc_PCD=0, ibuf=0, redir_pc=0, immediately and asynchronously.
REQ-026 Reset mid-request SHALL abandon the outstanding request; a late imem_valid in the first cycle after reset is treated as the response to RESET_PC.

Structure
REQ-027 Shared package SHALL hold the fetch-state enum, NOP_INSTR and RESET_PC defaults.
REQ-028 The F/D pipeline register SHALL be one sub-module, fd_reg (Stall/Flush inputs, bubble on Flush).

Verification
REQ-029 Zero-wait ROM, Stall=0 from reset: InstrD sequence = mem[0],mem[4],mem[8]; PCD = 0,4,8; inc_PCD = 4,8,12.
REQ-030 imem_valid delayed 3 cycles: 3 bubbles (NOP_INSTR) on InstrD, then instruction; PCF unchanged until valid.
REQ-031 Stall=1 for 2 cycles as valid arrives: state HOLD, imem_req=0, InstrD held; on release InstrD=buffered word, PCF+=4.
REQ-032 PCSrcE=1, PCTargetE=32'h100 while waiting: DROP; stale response discarded; next imem_addr=32'h100, no stale word reaches InstrD.
REQ-033 Flush=1 with Stall=1: InstrD=NOP_INSTR, PCD=0 next cycle.
REQ-034 rst asserted mid-request: outputs at reset values same cycle; imem_addr=RESET_PC after release.
